regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core: NUM_READ combinational read ports and one synchronous write port.
- x0 is hardwired to zero.
- Includes an optional write-to-read bypass and a per-register busy scoreboard. Issue sets a register's busy bit; writeback clears it. Decode uses the busy bits for hazard detection.
- Replaces the single-port register file and sits between decode (read/issue) and writeback.

Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of architectural registers (power of two, >=2)
- ADDR_W, 5, address width; must equal log2(DEPTH)
- NUM_READ, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data and busy-clear visible on read ports; 0 = visible next cycle

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; clears all registers and busy bits
- raddr  input  NUM_READ*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rdata  output  NUM_READ*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
- rbusy  output  NUM_READ  busy bit of the register addressed by each read port
- we  input  1  writeback enable
- waddr  input  ADDR_W  writeback destination
- wdata  input  WIDTH  writeback data
- issue_valid  input  1  an instruction with destination issue_rd is issued this cycle
- issue_rd  input  ADDR_W  destination register of the issued instruction
- flush  input  1  clears all busy bits (pipeline flush); register data untouched
- busy_count  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: on a rising edge with rst=1, all DEPTH registers become 0, all busy bits 0, busy_count 0. rst has priority over we, issue_valid and flush. rst asserted mid-operation discards any pending write that cycle.
- Write: if we=1 and waddr!=0, reg[waddr] <= wdata at the edge. A write to x0 is ignored.
- Read: combinational, zero latency. rdata_k = 0 when raddr_k==0.
  - BYPASS=1 and we=1 and waddr==raddr_k!=0: rdata_k = wdata.
  - Otherwise rdata_k = reg[raddr_k].
  - All read ports are independent; any number may address the same register.
- Busy scoreboard, per register r!=0, next-state priority:
  - rst → 0
  - flush → 0 (an issue in the same cycle as flush is also dropped)
  - issue_valid && issue_rd==r → 1 (issue wins over a same-cycle writeback to r)
  - we && waddr==r → 0
  - else hold
- busy[0] is constant 0. Issue to x0 is ignored.
- rbusy_k: busy[raddr_k]. With BYPASS=1, rbusy_k is forced 0 when we=1 and waddr==raddr_k and that register is not also being issued this cycle. With BYPASS=0, rbusy_k is the registered value only.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- busy_count: registered population count of the busy bits. It is updated in the same edge as the bits and always equals popcount(busy). Maximum value is DEPTH-1.
- No X propagation: every output is defined whenever rst has been applied once.

Test Plan:
- Reset: rst=1 for 2 cycles after random writes → rdata all 0, rbusy all 0, busy_count=0. Write during the rst cycle (we=1, waddr=5, wdata=0xDEAD_BEEF) → reg5 still reads 0.
- x0 guard: we=1, waddr=0, wdata=0xFFFF_FFFF; issue_valid=1, issue_rd=0 → raddr0=0 reads 0, rbusy=0, busy_count=0.
- Write/read and bypass: write reg7=0x1234_5678 while raddr0=7.
  - BYPASS=1: rdata0=0x1234_5678 in the same cycle.
  - BYPASS=0: old value in the same cycle, 0x1234_5678 next cycle.
  - raddr1=7 simultaneously shows the identical value.
- Scoreboard: issue rd=3 → next cycle rbusy=1 for raddr=3, busy_count=1. Writeback rd=3 → BYPASS=1 shows rbusy=0 in the same cycle; busy_count=0 next cycle.
- Simultaneous events: issue rd=9 and writeback rd=9 in the same cycle → busy[9]=1 afterwards, data updated. Issue rd=4,5,6 over 3 cycles then flush with issue rd=8 → all busy 0, busy_count=0, register data unchanged.
- Full scoreboard: issue rd=1..31 on consecutive cycles → busy_count=31. Then writeback rd=31..1 → busy_count decrements by 1 each cycle to 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_READ combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional write-to-read
// bypass and a per-register busy scoreboard (issue sets, writeback clears).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   raddr/rdata/rbusy   packed read ports (port k at slice k)
//   we/waddr/wdata      writeback port
//   issue_valid/rd      marks a destination register busy
//   flush               clears every busy bit, data untouched
//   busy_count          registered popcount of the busy bits
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_READ*ADDR_W-1:0] raddr,
    output logic [NUM_READ*WIDTH-1:0]  rdata,
    output logic [NUM_READ-1:0]        rbusy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_count
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_busy_count;

    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  w_busy_pop;
    logic             w_wr;
    logic             w_iss;

    assign w_wr  = we && (waddr != '0);
    assign w_iss = issue_valid && (issue_rd != '0);

    // Issue is applied after the writeback clear so it wins on a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr)
                w_busy_nxt[waddr] = 1'b0;
            if (w_iss)
                w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Count the next-state bits so the count moves on the same edge.
    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < DEPTH; i++)
            w_busy_pop = w_busy_pop + (ADDR_W+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr)
                r_regs[waddr] <= wdata;
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_pop;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;
        logic [WIDTH-1:0]  w_data;
        logic              w_bsy;

        assign w_ra  = raddr[k*ADDR_W +: ADDR_W];
        assign w_hit = (BYPASS != 0) && w_wr && (waddr == w_ra);

        always_comb begin
            w_data = r_regs[w_ra];
            if (w_ra == '0)
                w_data = '0;
            else if (w_hit)
                w_data = wdata;
        end

        // A same-cycle issue to the register keeps it busy despite bypass.
        always_comb begin
            w_bsy = r_busy[w_ra];
            if (w_hit && !(w_iss && issue_rd == w_ra))
                w_bsy = 1'b0;
        end

        assign rdata[k*WIDTH +: WIDTH] = w_data;
        assign rbusy[k]                = w_bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: drives a BYPASS=1 and a BYPASS=0
// instance with the same stimulus and compares against a reference model.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;

    logic [1:0][63:0] rdata_o;
    logic [1:0][1:0]  rbusy_o;
    logic [1:0][5:0]  bcnt_o;

    int checks;
    int failures;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_mp #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_o[0]),
        .rbusy(rbusy_o[0]), .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .busy_count(bcnt_o[0])
    );

    regfile_mp #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_o[1]),
        .rbusy(rbusy_o[1]), .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .busy_count(bcnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state updated from the rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (flush)
                    m_busy[r] = 1'b0;
                else if (issue_valid && issue_rd == r)
                    m_busy[r] = 1'b1;
                else if (we && waddr == r)
                    m_busy[r] = 1'b0;
            end
            if (we && waddr != 0)
                m_regs[waddr] = wdata;
        end
    end

    function automatic int mcount();
        int n = 0;
        for (int r = 0; r < 32; r++)
            n += m_busy[r];
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; waddr = 0; wdata = 0;
        issue_valid = 0; issue_rd = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 6; i++) begin
            we = 1; waddr = 5'($urandom_range(1, 31));
            wdata = $urandom;
            issue_valid = 1; issue_rd = 5'($urandom_range(1, 31));
            step();
        end
        rst = 1; we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        issue_valid = 1; issue_rd = 5;
        step();
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bcnt_o[b] !== 6'd0) begin
                failures++;
                $display("FAIL reset_cnt dut%0d got=%0d exp=0", b, bcnt_o[b]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (rdata_o[b] !== 64'd0 || rbusy_o[b] !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_rd dut%0d a=%0d got=%h/%b exp=0/00",
                             b, a, rdata_o[b], rbusy_o[b]);
                end
            end
        end
    endtask

    task automatic test_x0();
        idle();
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        issue_valid = 1; issue_rd = 0; raddr = 10'd0;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rdata_o[b][31:0] !== 32'd0 || rbusy_o[b][0] !== 1'b0) begin
                failures++;
                $display("FAIL x0_same dut%0d got=%h/%b exp=0/0",
                         b, rdata_o[b][31:0], rbusy_o[b][0]);
            end
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rdata_o[b][31:0] !== 32'd0 || rbusy_o[b][0] !== 1'b0 ||
                bcnt_o[b] !== 6'd0) begin
                failures++;
                $display("FAIL x0_next dut%0d got=%h/%b/%0d exp=0/0/0",
                         b, rdata_o[b][31:0], rbusy_o[b][0], bcnt_o[b]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        logic [31:0] exp;
        idle();
        old = m_regs[7];
        raddr = {5'd7, 5'd7};
        we = 1; waddr = 7; wdata = 32'h1234_5678;
        #1;
        for (int b = 0; b < 2; b++) begin
            exp = (b == 1) ? 32'h1234_5678 : old;
            checks++;
            if (rdata_o[b][31:0] !== exp || rdata_o[b][63:32] !== exp) begin
                failures++;
                $display("FAIL bypass_same dut%0d got=%h exp=%h,%h",
                         b, rdata_o[b], exp, exp);
            end
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rdata_o[b] !== {2{32'h1234_5678}}) begin
                failures++;
                $display("FAIL bypass_next dut%0d got=%h exp=%h",
                         b, rdata_o[b], {2{32'h1234_5678}});
            end
        end
    endtask

    task automatic test_scoreboard();
        idle();
        raddr = {5'd0, 5'd3};
        issue_valid = 1; issue_rd = 3;
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rbusy_o[b][0] !== 1'b1 || bcnt_o[b] !== 6'd1) begin
                failures++;
                $display("FAIL sb_issue dut%0d got=%b/%0d exp=1/1",
                         b, rbusy_o[b][0], bcnt_o[b]);
            end
        end
        we = 1; waddr = 3; wdata = 32'h0000_0333;
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rbusy_o[b][0] !== (b == 0)) begin
                failures++;
                $display("FAIL sb_wb_same dut%0d got=%b exp=%b",
                         b, rbusy_o[b][0], (b == 0));
            end
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rbusy_o[b][0] !== 1'b0 || bcnt_o[b] !== 6'd0) begin
                failures++;
                $display("FAIL sb_wb_next dut%0d got=%b/%0d exp=0/0",
                         b, rbusy_o[b][0], bcnt_o[b]);
            end
        end
    endtask

    task automatic test_simultaneous();
        idle();
        raddr = {5'd7, 5'd9};
        issue_valid = 1; issue_rd = 9;
        we = 1; waddr = 9; wdata = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (rbusy_o[1][0] !== 1'b0) begin
            failures++;
            $display("FAIL sim_same dut1 got=%b exp=0", rbusy_o[1][0]);
        end
        step();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rbusy_o[b][0] !== 1'b1 || rdata_o[b][31:0] !== 32'hA5A5_5A5A ||
                bcnt_o[b] !== 6'd1) begin
                failures++;
                $display("FAIL sim_iss_wb dut%0d got=%b/%h/%0d exp=1/a5a55a5a/1",
                         b, rbusy_o[b][0], rdata_o[b][31:0], bcnt_o[b]);
            end
        end
        for (int r = 4; r <= 6; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            step();
        end
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bcnt_o[b] !== 6'd4) begin
                failures++;
                $display("FAIL sim_cnt4 dut%0d got=%0d exp=4", b, bcnt_o[b]);
            end
        end
        flush = 1; issue_valid = 1; issue_rd = 8;
        step();
        idle();
        raddr = {5'd8, 5'd4};
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bcnt_o[b] !== 6'd0 || rbusy_o[b] !== 2'b00) begin
                failures++;
                $display("FAIL flush dut%0d got=%0d/%b exp=0/00",
                         b, bcnt_o[b], rbusy_o[b]);
            end
        end
        raddr = {5'd7, 5'd9};
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (rdata_o[b] !== {32'h1234_5678, 32'hA5A5_5A5A}) begin
                failures++;
                $display("FAIL flush_data dut%0d got=%h exp=%h", b,
                         rdata_o[b], {32'h1234_5678, 32'hA5A5_5A5A});
            end
        end
    endtask

    task automatic test_full();
        idle();
        for (int r = 1; r < 32; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            step();
        end
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bcnt_o[b] !== 6'd31) begin
                failures++;
                $display("FAIL full_cnt dut%0d got=%0d exp=31", b, bcnt_o[b]);
            end
        end
        for (int r = 31; r >= 1; r--) begin
            we = 1; waddr = 5'(r); wdata = 32'(r * 3);
            step();
            for (int b = 0; b < 2; b++) begin
                checks++;
                if (bcnt_o[b] !== 6'(r - 1)) begin
                    failures++;
                    $display("FAIL drain_cnt dut%0d r=%0d got=%0d exp=%0d",
                             b, r, bcnt_o[b], r - 1);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [4:0]  ra;
        logic [31:0] er;
        logic        eb;
        bit          byp;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr[9:5] = ($urandom_range(0, 2) == 0) ? issue_rd : 5'($urandom);
            #1;
            for (int b = 0; b < 2; b++) begin
                byp = (b == 1);
                for (int k = 0; k < 2; k++) begin
                    ra = raddr[k*5 +: 5];
                    if (ra == 0)
                        er = 32'd0;
                    else if (byp && we && waddr == ra)
                        er = wdata;
                    else
                        er = m_regs[ra];
                    if (byp && we && ra != 0 && waddr == ra &&
                        !(issue_valid && issue_rd == ra))
                        eb = 1'b0;
                    else
                        eb = m_busy[ra];
                    checks++;
                    if (rdata_o[b][k*32 +: 32] !== er ||
                        rbusy_o[b][k] !== eb) begin
                        failures++;
                        $display("FAIL rand_rd dut%0d n=%0d p%0d a=%0d got=%h/%b exp=%h/%b",
                                 b, n, k, ra, rdata_o[b][k*32 +: 32],
                                 rbusy_o[b][k], er, eb);
                    end
                end
                checks++;
                if (bcnt_o[b] !== 6'(mcount())) begin
                    failures++;
                    $display("FAIL rand_cnt dut%0d n=%0d got=%0d exp=%0d",
                             b, n, bcnt_o[b], mcount());
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle();
        raddr = 10'd0;
        rst = 1;
        step();
        step();
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
